// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen
// Zero-wait-state Avalon-MM GPIO slave. Holds a WIDTH-bit output register
// with atomic set/clear, a per-bit direction register, synchronised inputs
// with edge capture and a maskable level interrupt, and a timed pulse
// generator that inverts selected output bits for PULSE_LEN cycles.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    register select (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//              4 OUTSET, 5 OUTCLR, 6 PULSE, 7 reserved)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data, bits above WIDTH ignored
//   readdata   combinational read data, bits above WIDTH are zero
//   in_port    asynchronous external inputs
//   out_port   output drive values (pulse inversion applied)
//   oe         per-bit output enable (direction register)
//   irq        level interrupt, active high
module avalon_pio_gen #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               PULSE_LEN   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [15:0] PULSE_RELOAD = 16'(PULSE_LEN);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;
  localparam logic [2:0] A_PULSE   = 3'd6;

  // Saturating increment for the 2-bit arm counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] pulse_mask;
  logic [15:0]      pulse_cnt;
  logic [1:0]       arm_cnt;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             armed;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] cap_clr;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign armed     = (arm_cnt == 2'd3);

  // Stage s1/s2: metastability synchroniser; s3: one-cycle history of s2
  // so edges can be seen as a difference between s2 and s3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      arm_cnt <= 2'd0;
    end else begin
      s1      <= in_port;
      s2      <= s1;
      s3      <= s2;
      arm_cnt <= sat_inc2(arm_cnt);
    end
  end

  // Until armed, the synchroniser is still filling from its reset zeros,
  // so any apparent edge is just the power-up input level.
  always_comb begin
    edges = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edges = s2 & ~s3;
        1:       edges = ~s2 & s3;
        default: edges = s2 ^ s3;
      endcase
    end
  end

  assign cap_clr = (wr_en && address == A_EDGECAP) ? wd : '0;

  // Register stage: bus writes, edge capture, pulse timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= RESET_VALUE;
      dir        <= DIR_RESET;
      irq_mask   <= '0;
      edge_cap   <= '0;
      pulse_mask <= '0;
      pulse_cnt  <= 16'd0;
    end else begin
      // A new edge beats a write-1-to-clear landing on the same bit.
      edge_cap <= (edge_cap & ~cap_clr) | edges;

      if (wr_en) begin
        case (address)
          A_DATA:    data_out <= wd;
          A_DIR:     dir      <= wd;
          A_IRQMASK: irq_mask <= wd;
          A_OUTSET:  data_out <= data_out | wd;
          A_OUTCLR:  data_out <= data_out & ~wd;
          default:   ;
        endcase
      end

      // A rewrite restarts the timer and keeps already-pulsed bits
      // inverted, so an extended pulse never glitches.
      if (wr_en && address == A_PULSE) begin
        pulse_mask <= pulse_mask | wd;
        pulse_cnt  <= PULSE_RELOAD;
      end else if (pulse_cnt != 16'd0) begin
        pulse_cnt <= pulse_cnt - 16'd1;
        if (pulse_cnt == 16'd1) begin
          pulse_mask <= '0;
        end
      end
    end
  end

  assign out_port = (pulse_cnt != 16'd0) ? (data_out ^ pulse_mask) : data_out;
  assign oe       = dir;
  assign irq      = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:    readdata[WIDTH-1:0] = (dir & data_out) | (~dir & s2);
      A_DIR:     readdata[WIDTH-1:0] = dir;
      A_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      A_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      A_PULSE:   readdata[WIDTH-1:0] = pulse_mask;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Testbench for avalon_pio_gen (WIDTH=8, RESET_VALUE=8'hA5, rising edges,
// PULSE_LEN=16). A cycle-indexed model predicts outputs from the register
// rules; literal checks pin the model at the points of interest.
module tb_avalon_pio_gen;

  localparam int         W    = 8;
  localparam logic [7:0] RV   = 8'hA5;
  localparam int         PLEN = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'hFF;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  avalon_pio_gen #(
    .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(8'h00), .EDGE_TYPE(0), .PULSE_LEN(PLEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_e counts clock edges since reset release; in_at[e] is in_port
  // sampled at edge e. The synchronised value after edge e is in_at[e-1];
  // an edge first becomes capturable at edge 4.
  logic [7:0] m_dout, m_dir, m_mask, m_cap, m_pmask;
  int         m_e, m_pend;
  logic [7:0] in_at [0:8191];

  function automatic logic [7:0] m_events();
    logic [7:0] cur, prev;
    if (m_e + 1 < 4) return 8'h00;
    cur  = in_at[(m_e - 1) % 8192];
    prev = in_at[(m_e - 2) % 8192];
    return cur & ~prev;
  endfunction

  function automatic logic [7:0] m_sync();
    if (m_e < 2) return 8'h00;
    return in_at[(m_e - 1) % 8192];
  endfunction

  logic       m_wr;
  logic [7:0] m_wd;
  assign m_wr = chipselect && !write_n;
  assign m_wd = writedata[7:0];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dout  <= RV;
      m_dir   <= 8'h00;
      m_mask  <= 8'h00;
      m_cap   <= 8'h00;
      m_pmask <= 8'h00;
      m_e     <= 0;
      m_pend  <= 0;
    end else begin
      m_e <= m_e + 1;
      in_at[(m_e + 1) % 8192] <= in_port;
      m_cap <= (m_cap & ~((m_wr && address == 3'd3) ? m_wd : 8'h00)) | m_events();
      if (m_wr && address == 3'd0) m_dout <= m_wd;
      if (m_wr && address == 3'd4) m_dout <= m_dout | m_wd;
      if (m_wr && address == 3'd5) m_dout <= m_dout & ~m_wd;
      if (m_wr && address == 3'd1) m_dir  <= m_wd;
      if (m_wr && address == 3'd2) m_mask <= m_wd;
      if (m_wr && address == 3'd6) begin
        m_pmask <= m_pmask | m_wd;
        m_pend  <= m_e + 1 + PLEN;
      end else if (m_e + 1 >= m_pend) begin
        m_pmask <= 8'h00;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0]  e_out;
    logic [31:0] e_rd;
    e_out = (m_e < m_pend) ? (m_dout ^ m_pmask) : m_dout;
    case (address)
      3'd0:    e_rd = {24'h0, (m_dir & m_dout) | (~m_dir & m_sync())};
      3'd1:    e_rd = {24'h0, m_dir};
      3'd2:    e_rd = {24'h0, m_mask};
      3'd3:    e_rd = {24'h0, m_cap};
      3'd6:    e_rd = {24'h0, m_pmask};
      default: e_rd = 32'h0;
    endcase
    chk("out_port", {24'h0, out_port}, {24'h0, e_out});
    chk("oe", {24'h0, oe}, {24'h0, m_dir});
    chk("irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    chk("readdata", readdata, e_rd);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    address    = a;
    writedata  = {24'h5A5A5A, d};
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int cnt;

    // Power-up with inputs high: no capture, reset outputs.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("rst_out_port", {24'h0, out_port}, 32'hA5);
    chk("rst_oe", {24'h0, oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd(3'd3, r); chk("rst_edgecap", r, 32'h0);
    rd(3'd6, r); chk("rst_pulse", r, 32'h0);

    // Direction-mixed DATA read, set/clear.
    wr(3'd1, 8'h0F);
    wr(3'd0, 8'h3C);
    in_port = 8'h90;
    repeat (3) tick();
    rd(3'd0, r); chk("data_mixed", r, 32'h9C);
    wr(3'd4, 8'h01);
    wr(3'd5, 8'h04);
    chk("set_clr_out", {24'h0, out_port}, 32'h39);
    chk("dir_oe", {24'h0, oe}, 32'h0F);

    // Rising edge on bit1 with mask.
    wr(3'd2, 8'h02);
    in_port = 8'h92;
    tick(); tick();
    rd(3'd3, r); chk("cap_before_e2", r, 32'h0);
    tick();
    rd(3'd3, r); chk("cap_after_e2", r, 32'h02);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(3'd3, 8'h02);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // Set-wins collision: bits 0,1 captured, clear 0x03 on bit1 re-capture.
    in_port = 8'h90; repeat (4) tick();
    in_port = 8'h93; repeat (3) tick();
    rd(3'd3, r); chk("cap_two", r, 32'h03);
    in_port = 8'h90; repeat (4) tick();
    in_port = 8'h92; tick(); tick();
    wr(3'd3, 8'h03);
    rd(3'd3, r); chk("cap_set_wins", r, 32'h02);
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    wr(3'd3, 8'hFF);

    // Single pulse: exactly 16 cycles.
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h80);
    chk("pulse_first", {24'h0, out_port}, 32'h80);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_port == 8'h80) cnt++;
      if (i == 3) begin rd(3'd6, r); chk("pulse_mask_rd", r, 32'h80); end
      tick();
    end
    chk("pulse_len", cnt, 16);
    rd(3'd6, r); chk("pulse_mask_done", r, 32'h0);

    // Extended pulse: rewrite 10 cycles after the first write edge.
    wr(3'd6, 8'h80);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_port == 8'h80) cnt++;
      if (i == 9) begin
        address = 3'd6; writedata = 32'h80; chipselect = 1'b1; write_n = 1'b0;
      end
      tick();
      chipselect = 1'b0; write_n = 1'b1;
    end
    chk("pulse_extended", cnt, 26);

    // Reset mid-pulse, then power-up arming again with inputs high.
    in_port = 8'hFF;
    wr(3'd6, 8'h80);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out", {24'h0, out_port}, 32'hA5);
    chk("rst_mid_oe", {24'h0, oe}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(3'd3, r); chk("rearm_edgecap", r, 32'h0);
    rd(3'd6, r); chk("rearm_pulse", r, 32'h0);
    rd(3'd2, r); chk("rearm_mask", r, 32'h0);

    // Capture works once armed.
    in_port = 8'h00; repeat (4) tick();
    in_port = 8'hFF; repeat (3) tick();
    rd(3'd3, r); chk("armed_capture", r, 32'hFF);
    chk("armed_irq", {31'h0, irq}, 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gen.md
# avalon_pio_gen

Parametrised Avalon-MM general-purpose I/O peripheral for the Nios system: WIDTH-bit output register with atomic set/clear, per-bit direction, synchronised inputs with edge capture and maskable interrupt, and a timed output-pulse generator. It sits on the CPU data master as a zero-wait-state slave and replaces the fixed 2-bit output-only PIO instances in new subsystems.

## Interface
- WIDTH, 8: port width, 1..32
- RESET_VALUE, 0: data_out value after reset (WIDTH bits)
- DIR_RESET, 0: direction register after reset (1 = output)
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge
- PULSE_LEN, 16: pulse duration in clk cycles, 1..65535
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [31:WIDTH] ignored
- readdata  out  32  read data, combinational from address; bits [31:WIDTH] zero
- in_port  in  WIDTH  asynchronous external inputs
- out_port  out  WIDTH  output drive values
- oe  out  WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt, active high

## Operation
- Register map (write = chipselect & ~write_n):
  - 0 DATA: write loads data_out; read returns (oe & data_out) | (~oe & in_sync)
  - 1 DIR: read/write direction
  - 2 IRQMASK: read/write
  - 3 EDGECAP: read captured edges; write-1-to-clear
  - 4 OUTSET: write ORs into data_out; reads 0
  - 5 OUTCLR: write clears bits of data_out; reads 0
  - 6 PULSE: write ORs writedata into pulse_mask and reloads pulse counter to PULSE_LEN; read returns pulse_mask
  - 7 reserved: writes ignored, reads 0
- Input path: two-flop synchroniser (s1, s2) per bit, then delay flop s3; in_sync = s2.
- Edge detect: rising = s2 & ~s3, falling = ~s2 & s3, any = s2 ^ s3, per EDGE_TYPE; sets EDGECAP bits.
- Arming: 2-bit arm counter runs from reset; edge detection is gated off until counter saturates (3 cycles after reset release) so power-up input levels produce no captures.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Pulse: counter 16 bits; while counter != 0, out_port = data_out ^ pulse_mask; counter decrements each cycle; on transition 1 -> 0 pulse_mask clears. When counter == 0, out_port = data_out.
- Reset values: data_out = RESET_VALUE, DIR = DIR_RESET, IRQMASK = 0, EDGECAP = 0, pulse_mask = 0, counter = 0, s1/s2/s3 = 0, irq = 0, out_port = RESET_VALUE, oe = DIR_RESET.

## Timing
- Writes take effect at the clk edge of the write cycle; out_port/oe change after that edge. Reads are zero-latency, zero-wait.
- in_port change stable before edge E0: s2 updates at E1 (DATA read reflects it after E1); EDGECAP bit set at E2; irq asserted after E2 if masked in.
- Simultaneous edge capture and write-1-to-clear of same EDGECAP bit: set wins; other bits clear normally.
- Write to PULSE while active: mask ORed, counter restarts at PULSE_LEN (pulse extended, no glitch on already-pulsed bits).
- Write to DATA/OUTSET/OUTCLR during a pulse updates data_out; pulsed bits show new data_out inverted until expiry.
- Pulse with PULSE_LEN = N: out_port inverted for exactly N cycles after the write edge.
- Reset assertion mid-pulse or mid-capture: all state returns to reset values immediately (asynchronous); arming restarts.

## Test plan
- Reset, WIDTH=8, RESET_VALUE=8'hA5, in_port=8'hFF held -> out_port=8'hA5, oe=0, EDGECAP=0 after 10 cycles, irq=0.
- DIR=8'h0F, DATA=8'h3C, in_port=8'h90 -> read DATA = 8'h9C; OUTSET 8'h01 then OUTCLR 8'h04 -> out_port=8'h39.
- EDGE_TYPE=0, IRQMASK=8'h02, in_port bit1 0->1 -> EDGECAP=8'h02 two edges after sync edge, irq=1; write EDGECAP 8'h02 -> irq=0 next cycle.
- Rising edge on bit1 landing on same cycle as EDGECAP clear of bit1 -> bit1 remains 1.
- PULSE_LEN=16, data_out=0, write PULSE 8'h80 -> out_port=8'h80 for exactly 16 cycles then 8'h00, PULSE reads 0; rewrite at cycle 10 -> high 26 cycles total.
- Assert reset_n low mid-pulse (cycle 5) -> out_port=RESET_VALUE immediately, PULSE=0, no edges captured for 3 cycles after release.
